// File: rtl/mfp_ahb_sdram_wbuf_pkg.sv
// Shared encodings for the AHB-Lite posted-write buffer in front of the SDRAM controller.
package mfp_ahb_sdram_wbuf_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_X8  = 3'b000;
   localparam logic [2:0] HSIZE_X16 = 3'b001;
   localparam logic [2:0] HSIZE_X32 = 3'b010;

   localparam int ENTRY_W = 67;

   // Upstream (slave side) protocol states
   typedef enum logic [1:0] {
      U_IDLE  = 2'b00,
      U_WDATA = 2'b01,
      U_RD    = 2'b10,
      U_RDONE = 2'b11
   } ustate_t;

   // Downstream (master side) protocol states
   typedef enum logic [1:0] {
      M_IDLE = 2'b00,
      M_WR   = 2'b01,
      M_RD   = 2'b10
   } mstate_t;

   // One buffered write: byte address, transfer size, write data
   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] data;
   } wbuf_entry_t;

endpackage

// File: rtl/mfp_ahb_wbuf_fifo.sv
// Synchronous FIFO holding posted writes; head entry is always visible on dout.
module mfp_ahb_wbuf_fifo
   import mfp_ahb_sdram_wbuf_pkg::*;
#(
   parameter int DEPTH_LOG2 = 2,
   parameter int WIDTH      = ENTRY_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   COUNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
   localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2+1)'(1'b1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1'b1);

   logic [WIDTH-1:0]      mem_r [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_r;
   logic [DEPTH_LOG2-1:0] rd_ptr_r;
   logic [DEPTH_LOG2:0]   count_r;
   logic                  do_push_s;
   logic                  do_pop_s;

   // A pop frees a slot in the same cycle, so push is allowed while full if a pop coincides
   assign do_pop_s  = pop && (count_r != COUNT_ZERO);
   assign do_push_s = push && ((count_r != COUNT_FULL) || do_pop_s);

   // Entry storage, written at the tail
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers wrap naturally; occupancy tracks push/pop, unchanged when both fire
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {DEPTH_LOG2{1'b0}};
         rd_ptr_r <= {DEPTH_LOG2{1'b0}};
         count_r  <= COUNT_ZERO;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + COUNT_ONE;
            2'b01:   count_r <= count_r - COUNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   assign dout  = mem_r[rd_ptr_r];
   assign empty = (count_r == COUNT_ZERO);
   assign full  = (count_r == COUNT_FULL);
   assign count = count_r;

endmodule

// File: rtl/mfp_ahb_sdram_wbuf.sv
// Posted-write buffer: zero-wait upstream writes drain to SDRAM in the background;
// reads wait until every buffered write has reached SDRAM, then fetch one word.
module mfp_ahb_sdram_wbuf
   import mfp_ahb_sdram_wbuf_pkg::*;
#(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [31:0] HADDR,
   input  logic        HSEL,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADY,
   output logic        HRESP,
   output logic        M_HSEL,
   output logic [31:0] M_HADDR,
   output logic [1:0]  M_HTRANS,
   output logic [2:0]  M_HSIZE,
   output logic        M_HWRITE,
   output logic [31:0] M_HWDATA,
   input  logic [31:0] M_HRDATA,
   input  logic        M_HREADY
);

   localparam logic [DEPTH_LOG2:0] COUNT_ZERO = {(DEPTH_LOG2+1){1'b0}};

   ustate_t             u_state_r, u_next_s, decode_s;
   mstate_t             m_state_r, m_next_s;
   logic [31:0]         addr_r;
   logic [2:0]          size_r;
   logic                rd_pending_r;
   logic [31:0]         hrdata_r;
   logic                accept_s, lat_en_s, set_rd_s, rd_capture_s, rd_done_s;
   logic                push_s, pop_s, hready_s;
   logic                fifo_empty_s, fifo_full_s;
   logic [DEPTH_LOG2:0] fifo_count_s;
   wbuf_entry_t         push_entry_s, head_s;

   assign accept_s     = HSEL && ((HTRANS & HTRANS_NONSEQ) == HTRANS_NONSEQ);
   assign push_entry_s = {addr_r, size_r, HWDATA};

   mfp_ahb_wbuf_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (ENTRY_W)
   ) u_fifo (
      .clk   (HCLK),
      .rst_n (HRESETn),
      .push  (push_s),
      .pop   (pop_s),
      .din   (push_entry_s),
      .dout  (head_s),
      .empty (fifo_empty_s),
      .full  (fifo_full_s),
      .count (fifo_count_s)
   );

   // Where an upstream address phase leads when it is accepted
   always_comb begin
      decode_s = U_IDLE;
      if (accept_s) begin
         if (HWRITE) decode_s = U_WDATA;
         else        decode_s = U_RD;
      end else begin
         decode_s = U_IDLE;
      end
   end

   // Upstream FSM: write data phases push into the FIFO, reads stall until downstream returns data
   always_comb begin
      u_next_s     = u_state_r;
      hready_s     = 1'b1;
      push_s       = 1'b0;
      lat_en_s     = 1'b0;
      set_rd_s     = 1'b0;
      rd_capture_s = 1'b0;
      case (u_state_r)
         U_IDLE, U_RDONE: begin
            lat_en_s = accept_s;
            set_rd_s = accept_s && !HWRITE;
            u_next_s = decode_s;
         end
         U_WDATA: begin
            if (!fifo_full_s || pop_s) begin
               push_s   = 1'b1;
               lat_en_s = accept_s;
               set_rd_s = accept_s && !HWRITE;
               u_next_s = decode_s;
            end else begin
               hready_s = 1'b0;
               u_next_s = U_WDATA;
            end
         end
         U_RD: begin
            hready_s = 1'b0;
            if (rd_done_s) begin
               rd_capture_s = 1'b1;
               u_next_s     = U_RDONE;
            end else begin
               u_next_s = U_RD;
            end
         end
         default: begin
            hready_s = 1'b1;
            u_next_s = U_IDLE;
         end
      endcase
   end

   // Downstream FSM: a read only goes out once the FIFO is completely drained
   always_comb begin
      m_next_s  = m_state_r;
      M_HSEL    = 1'b0;
      M_HTRANS  = HTRANS_IDLE;
      M_HWRITE  = 1'b0;
      M_HADDR   = 32'h0000_0000;
      M_HSIZE   = 3'b000;
      M_HWDATA  = 32'h0000_0000;
      pop_s     = 1'b0;
      rd_done_s = 1'b0;
      case (m_state_r)
         M_IDLE: begin
            if (M_HREADY && rd_pending_r && (fifo_count_s == COUNT_ZERO)) begin
               M_HSEL   = 1'b1;
               M_HTRANS = HTRANS_NONSEQ;
               M_HADDR  = addr_r;
               M_HSIZE  = size_r;
               m_next_s = M_RD;
            end else if (M_HREADY && !fifo_empty_s) begin
               M_HSEL   = 1'b1;
               M_HTRANS = HTRANS_NONSEQ;
               M_HWRITE = 1'b1;
               M_HADDR  = head_s.addr;
               M_HSIZE  = head_s.size;
               m_next_s = M_WR;
            end else begin
               m_next_s = M_IDLE;
            end
         end
         M_WR: begin
            M_HWDATA = head_s.data;
            if (M_HREADY) begin
               pop_s    = 1'b1;
               m_next_s = M_IDLE;
            end else begin
               m_next_s = M_WR;
            end
         end
         M_RD: begin
            if (M_HREADY) begin
               rd_done_s = 1'b1;
               m_next_s  = M_IDLE;
            end else begin
               m_next_s = M_RD;
            end
         end
         default: begin
            m_next_s = M_IDLE;
         end
      endcase
   end

   // State registers for both FSMs
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         u_state_r <= U_IDLE;
         m_state_r <= M_IDLE;
      end else begin
         u_state_r <= u_next_s;
         m_state_r <= m_next_s;
      end
   end

   // Address-phase capture, read request flag and registered read data
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_r       <= 32'h0000_0000;
         size_r       <= 3'b000;
         rd_pending_r <= 1'b0;
         hrdata_r     <= 32'h0000_0000;
      end else begin
         if (lat_en_s) begin
            addr_r <= HADDR;
            size_r <= HSIZE;
         end
         if (set_rd_s)          rd_pending_r <= 1'b1;
         else if (rd_capture_s) rd_pending_r <= 1'b0;
         if (rd_capture_s) hrdata_r <= M_HRDATA;
      end
   end

   assign HRDATA = hrdata_r;
   assign HREADY = hready_s;
   assign HRESP  = 1'b0;

endmodule

// File: tb/tb_mfp_ahb_sdram_wbuf.sv
// Self-checking bench: pipelined upstream AHB master, wait-state SDRAM slave model,
// transfer log compared against an in-order reference of issued transactions.
module tb_mfp_ahb_sdram_wbuf;
   import mfp_ahb_sdram_wbuf_pkg::*;

   typedef struct packed {
      logic        w;
      logic [31:0] a;
      logic [2:0]  s;
      logic [31:0] d;
   } xfer_t;

   logic        HCLK, HRESETn;
   logic [31:0] HADDR, HWDATA, HRDATA, M_HADDR, M_HWDATA, M_HRDATA;
   logic        HSEL, HWRITE, HREADY, HRESP, M_HSEL, M_HWRITE, M_HREADY;
   logic [1:0]  HTRANS, M_HTRANS;
   logic [2:0]  HSIZE, M_HSIZE;

   int          n_checks = 0;
   int          n_errors = 0;
   xfer_t       obs_log[$];
   xfer_t       exp_log[$];
   logic [31:0] smem    [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] written[$];
   int          wait_cycles = 0;

   logic        prev_valid = 1'b0, prev_write = 1'b0;
   logic [31:0] prev_wdata = 32'h0, prev_exp = 32'h0;
   int          dp_idx = 0, first_stall = 0;
   logic        rec_pending = 1'b0;
   logic [2:0]  rel_count = 3'd0, post_count = 3'd0;

   mfp_ahb_sdram_wbuf #(.DEPTH_LOG2(2)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HSEL(HSEL), .HTRANS(HTRANS),
      .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
      .HRESP(HRESP), .M_HSEL(M_HSEL), .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS),
      .M_HSIZE(M_HSIZE), .M_HWRITE(M_HWRITE), .M_HWDATA(M_HWDATA), .M_HRDATA(M_HRDATA),
      .M_HREADY(M_HREADY)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1, "watchdog");
   end

   // SDRAM-side slave: accepts address phases, inserts wait_cycles wait states, logs transfers
   initial begin : slave
      logic        s_dphase, s_dwrite, s_done, s_acc, n_w;
      logic [31:0] s_daddr, n_a;
      logic [2:0]  s_dsize, n_s;
      int          s_wait;
      s_dphase = 1'b0; s_dwrite = 1'b0; s_daddr = 32'h0; s_dsize = 3'd0; s_wait = 0;
      n_w = 1'b0; n_a = 32'h0; n_s = 3'd0;
      M_HREADY = 1'b1; M_HRDATA = 32'h0;
      forever begin
         @(negedge HCLK);
         s_done = 1'b0; s_acc = 1'b0;
         if (!HRESETn) begin
            s_dphase = 1'b0;
            M_HREADY = 1'b1;
         end else begin
            s_done = s_dphase && M_HREADY;
            if (s_done && s_dwrite) begin
               smem[s_daddr] = M_HWDATA;
               obs_log.push_back('{1'b1, s_daddr, s_dsize, M_HWDATA});
            end
            s_acc = M_HREADY && M_HSEL && M_HTRANS[1];
            if (s_acc) begin
               n_a = M_HADDR; n_s = M_HSIZE; n_w = M_HWRITE;
               if (!M_HWRITE) obs_log.push_back('{1'b0, M_HADDR, M_HSIZE, 32'h0});
            end
         end
         @(posedge HCLK); #1;
         if (!HRESETn) begin
            s_dphase = 1'b0;
            M_HREADY = 1'b1;
         end else begin
            if (s_done) s_dphase = 1'b0;
            if (s_acc) begin
               s_dphase = 1'b1; s_daddr = n_a; s_dsize = n_s; s_dwrite = n_w;
               s_wait = wait_cycles;
            end
            if (s_dphase && s_wait > 0) begin
               M_HREADY = 1'b0;
               s_wait--;
            end else begin
               M_HREADY = 1'b1;
            end
            if (s_dphase && !s_dwrite && smem.exists(s_daddr)) M_HRDATA = smem[s_daddr];
            else M_HRDATA = 32'h0;
         end
      end
   end

   task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One upstream bus cycle: new address phase plus the data phase of the previous transfer
   task automatic bus_cycle(input logic act, input logic wr, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] wdata,
                            input logic [31:0] exp_rd);
      int   guard;
      logic stalled;
      HSEL = act; HTRANS = act ? HTRANS_NONSEQ : HTRANS_IDLE;
      HADDR = addr; HWRITE = wr; HSIZE = size; HWDATA = prev_wdata;
      guard = 0; stalled = 1'b0;
      @(negedge HCLK);
      while (HREADY !== 1'b1 && guard < 300) begin
         if (prev_valid && prev_write && first_stall == 0) begin
            first_stall = dp_idx;
            rec_pending = 1'b1;
         end
         stalled = 1'b1;
         @(posedge HCLK); #1; @(negedge HCLK);
         guard++;
      end
      if (guard >= 300) chk("hready_timeout", 68'(HREADY), 68'd1);
      if (stalled && rec_pending) rel_count = dut.u_fifo.count;
      if (prev_valid && !prev_write) chk("hrdata", 68'(HRDATA), 68'(prev_exp));
      @(posedge HCLK); #1;
      if (stalled && rec_pending) begin
         post_count  = dut.u_fifo.count;
         rec_pending = 1'b0;
      end
      prev_valid = act; prev_write = wr; prev_wdata = wr ? wdata : 32'h0; prev_exp = exp_rd;
      if (act) dp_idx++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 32'h0, HSIZE_X32, 32'h0, 32'h0);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      ref_mem[a] = d;
      exp_log.push_back('{1'b1, a, s, d});
      bus_cycle(1'b1, 1'b1, a, s, d, 32'h0);
   endtask

   task automatic do_read(input logic [31:0] a);
      logic [31:0] e;
      e = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
      exp_log.push_back('{1'b0, a, HSIZE_X32, 32'h0});
      bus_cycle(1'b1, 1'b0, a, HSIZE_X32, 32'h0, e);
   endtask

   task automatic drain();
      int g;
      g = 0;
      idle(1);
      while ((obs_log.size() != exp_log.size() || dut.u_fifo.empty !== 1'b1) && g < 400) begin
         idle(1);
         g++;
      end
      chk("drain_empty", 68'(dut.u_fifo.empty), 68'd1);
   endtask

   task automatic compare_logs(input string tag);
      chk({tag, "_len"}, 68'(obs_log.size()), 68'(exp_log.size()));
      for (int i = 0; i < exp_log.size() && i < obs_log.size(); i++)
         chk($sformatf("%s_%0d", tag, i), obs_log[i], exp_log[i]);
      obs_log.delete();
      exp_log.delete();
   endtask

   task automatic start_test();
      dp_idx = 0; first_stall = 0; rec_pending = 1'b0;
   endtask

   initial begin : main
      logic [31:0] a, d;
      logic [2:0]  sz;
      HRESETn = 1'b1; HSEL = 1'b0; HTRANS = HTRANS_IDLE; HADDR = 32'h0;
      HSIZE = HSIZE_X32; HWRITE = 1'b0; HWDATA = 32'h0;
      #1 HRESETn = 1'b0;
      #2;
      chk("rst_hready",   68'(HREADY),   68'd1);
      chk("rst_hrdata",   68'(HRDATA),   68'd0);
      chk("rst_hresp",    68'(HRESP),    68'd0);
      chk("rst_m_hsel",   68'(M_HSEL),   68'd0);
      chk("rst_m_htrans", 68'(M_HTRANS), 68'd0);
      chk("rst_m_haddr",  68'(M_HADDR),  68'd0);
      chk("rst_m_hwdata", 68'(M_HWDATA), 68'd0);
      @(posedge HCLK); @(posedge HCLK); #1;
      HRESETn = 1'b1;
      idle(2);

      // single word write, no wait states expected upstream
      start_test(); wait_cycles = 1;
      do_write(32'h0000_0100, HSIZE_X32, 32'hDEAD_BEEF);
      drain();
      chk("single_no_stall", 68'(first_stall), 68'd0);
      compare_logs("single");

      // eight back-to-back writes against a slow slave: fifth data phase stalls
      start_test(); wait_cycles = 6;
      for (int i = 0; i < 8; i++) do_write(32'(i * 4), HSIZE_X32, $urandom);
      drain();
      chk("burst_first_stall", 68'(first_stall), 68'd5);
      chk("burst_count_at_release", 68'(rel_count), 68'd4);
      chk("burst_count_after_push_pop", 68'(post_count), 68'd4);
      compare_logs("burst");

      // read-after-write: read must go downstream after the write and see its data
      start_test(); wait_cycles = 2;
      do_write(32'h0000_0040, HSIZE_X32, 32'h1234_5678);
      do_read(32'h0000_0040);
      drain();
      compare_logs("raw");

      // byte write passes size and unaligned address through unchanged
      start_test(); wait_cycles = 0;
      do_write(32'h0000_0203, HSIZE_X8, 32'hAA00_0000);
      drain();
      compare_logs("byte");

      // asynchronous reset with three entries queued and a write data phase in flight
      start_test(); wait_cycles = 10;
      do_write(32'h0000_0300, HSIZE_X32, 32'h3030_0000);
      do_write(32'h0000_0304, HSIZE_X32, 32'h3030_0004);
      do_write(32'h0000_0308, HSIZE_X32, 32'h3030_0008);
      idle(1);
      chk("rst_pre_count",  68'(dut.u_fifo.count), 68'd3);
      chk("rst_pre_hwdata", 68'(M_HWDATA), 68'h3030_0000);
      #2 HRESETn = 1'b0;
      #1;
      chk("arst_hready",   68'(HREADY),   68'd1);
      chk("arst_hrdata",   68'(HRDATA),   68'd0);
      chk("arst_m_hsel",   68'(M_HSEL),   68'd0);
      chk("arst_m_htrans", 68'(M_HTRANS), 68'd0);
      chk("arst_m_hwrite", 68'(M_HWRITE), 68'd0);
      chk("arst_m_haddr",  68'(M_HADDR),  68'd0);
      chk("arst_m_hsize",  68'(M_HSIZE),  68'd0);
      chk("arst_m_hwdata", 68'(M_HWDATA), 68'd0);
      obs_log.delete(); exp_log.delete();
      prev_valid = 1'b0; prev_write = 1'b0; prev_wdata = 32'h0;
      @(posedge HCLK); @(posedge HCLK); #1;
      HRESETn = 1'b1;
      idle(30);
      chk("post_reset_no_stale_len", 68'(obs_log.size()), 68'd0);
      chk("post_reset_empty", 68'(dut.u_fifo.empty), 68'd1);
      obs_log.delete();

      // randomized mix of writes and reads against the reference memory
      start_test();
      for (int t = 0; t < 24; t++) begin
         wait_cycles = $urandom_range(0, 3);
         if (written.size() > 0 && $urandom_range(0, 2) == 0) begin
            do_read(written[$urandom_range(0, written.size() - 1)]);
         end else begin
            a  = 32'h0000_1000 + 32'($urandom_range(0, 15)) * 32'd4;
            sz = 3'($urandom_range(0, 2));
            d  = $urandom;
            do_write(a, sz, d);
            written.push_back(a);
         end
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      drain();
      compare_logs("rand");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
